// File: rtl/door_system.sv
// Single-door access controller: card-gated entry, tailgate stop, card timeout and LED drive.
// Optional macro DOOR_SYSTEM_BLINK_EN makes RED_LED blink in DENIED and STOP.
module door_system #(
    parameter int WAIT_CYCLES = 64,
    parameter int DENY_CYCLES = 32,
    parameter int BLINK_HALF  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_entrance,
    input  logic       sensor_exit,
    input  logic       card_valid,
    output logic       GREEN_LED,
    output logic       RED_LED,
    output logic       door_status,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_CARD = 3'd1,
        OPEN      = 3'd2,
        DENIED    = 3'd3,
        STOP      = 3'd4
    } state_t;

    localparam int MAX_WD = (WAIT_CYCLES > DENY_CYCLES) ? WAIT_CYCLES : DENY_CYCLES;
    localparam int MAX_ALL = (MAX_WD > 2 * BLINK_HALF) ? MAX_WD : 2 * BLINK_HALF;
    localparam int CW = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] DENY_LAST = CW'(DENY_CYCLES - 1);

    state_t        state_q, next_state;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          green_d, red_d, door_d;
    logic          alarm_red;

    assign fsm_state = state_q;

    always_comb begin
        next_state = state_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (sensor_entrance) next_state = WAIT_CARD;
            end
            WAIT_CARD: begin
                if (!sensor_entrance)        next_state = IDLE;
                else if (card_valid)         next_state = OPEN;
                else if (cnt_q == WAIT_LAST) next_state = DENIED;
                else                         cnt_d = cnt_q + 1'b1;
            end
            OPEN: begin
                if (sensor_exit && sensor_entrance) next_state = STOP;
                else if (sensor_exit)               next_state = IDLE;
            end
            DENIED: begin
                if (cnt_q == DENY_LAST) next_state = sensor_entrance ? WAIT_CARD : IDLE;
                else                    cnt_d = cnt_q + 1'b1;
            end
            STOP: begin
                if (!sensor_entrance && !sensor_exit) next_state = IDLE;
                else if (card_valid)                  next_state = OPEN;
            end
            default: next_state = IDLE;
        endcase
        // Every state change restarts the dwell counter.
        if (next_state != state_q) cnt_d = '0;
    end

`ifdef DOOR_SYSTEM_BLINK_EN
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);
    logic [CW-1:0] blink_q, blink_d;

    // Blink phase restarts lit on entry and toggles after each BLINK_HALF cycles.
    always_comb begin
        if (next_state != state_q) begin
            blink_d   = '0;
            alarm_red = 1'b1;
        end else if (blink_q == BLINK_LAST) begin
            blink_d   = '0;
            alarm_red = ~RED_LED;
        end else begin
            blink_d   = blink_q + 1'b1;
            alarm_red = RED_LED;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) blink_q <= '0;
        else        blink_q <= blink_d;
    end
`else
    assign alarm_red = 1'b1;
`endif

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        door_d  = 1'b0;
        green_d = 1'b0;
        red_d   = 1'b0;
        case (next_state)
            WAIT_CARD: red_d = 1'b1;
            OPEN: begin
                door_d  = 1'b1;
                green_d = 1'b1;
            end
            DENIED, STOP: red_d = alarm_red;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            door_status <= 1'b0;
            GREEN_LED   <= 1'b0;
            RED_LED     <= 1'b0;
        end else begin
            state_q     <= next_state;
            cnt_q       <= cnt_d;
            door_status <= door_d;
            GREEN_LED   <= green_d;
            RED_LED     <= red_d;
        end
    end

endmodule

// File: tb/tb_door_system.sv
// Directed testbench for door_system: reset, entry, tailgate, timeout, abort and async reset.
module tb_door_system;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_OPEN   = 3'd2;
    localparam logic [2:0] S_DENIED = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic       clk;
    logic       reset;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic       card_valid;
    logic       GREEN_LED;
    logic       RED_LED;
    logic       door_status;
    logic [2:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    door_system #(
        .WAIT_CYCLES(64),
        .DENY_CYCLES(32),
        .BLINK_HALF (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sensor_entrance(sensor_entrance),
        .sensor_exit    (sensor_exit),
        .card_valid     (card_valid),
        .GREEN_LED      (GREEN_LED),
        .RED_LED        (RED_LED),
        .door_status    (door_status),
        .fsm_state      (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic door, input logic green,
                              input logic red, input logic [2:0] st);
        check_eq({tag, "_door"}, 32'(door_status), 32'(door));
        check_eq({tag, "_green"}, 32'(GREEN_LED), 32'(green));
        check_eq({tag, "_red"}, 32'(RED_LED), 32'(red));
        check_eq({tag, "_state"}, 32'(fsm_state), 32'(st));
    endtask

    // Red level expected i cycles after entering DENIED or STOP.
    function automatic logic alarm_red(input int i);
`ifdef DOOR_SYSTEM_BLINK_EN
        return ((i / 4) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    initial begin
        reset = 1'b0;
        sensor_entrance = 1'b0;
        sensor_exit = 1'b0;
        card_valid = 1'b0;

        // Reset held with idle inputs, then with a person at the entrance.
        repeat (5) tick();
        check_outs("rst_idle", 0, 0, 0, S_IDLE);
        sensor_entrance = 1'b1;
        repeat (5) tick();
        check_outs("rst_entr", 0, 0, 0, S_IDLE);
        reset = 1'b1;

        // Normal entry.
        tick();
        check_outs("entry_wait", 0, 0, 1, S_WAIT);
        card_valid = 1'b1;
        tick();
        check_outs("entry_open", 1, 1, 0, S_OPEN);
        card_valid = 1'b0;
        tick();
        check_outs("entry_hold", 1, 1, 0, S_OPEN);
        sensor_entrance = 1'b0;
        sensor_exit = 1'b1;
        tick();
        check_outs("entry_pass", 0, 0, 0, S_IDLE);
        sensor_exit = 1'b0;

        // Tailgate into STOP, blink/steady red while held, card re-opens.
        sensor_entrance = 1'b1;
        tick();
        card_valid = 1'b1;
        tick();
        check_outs("tg_open", 1, 1, 0, S_OPEN);
        card_valid = 1'b0;
        sensor_exit = 1'b1;
        tick();
        check_outs("tg_stop", 0, 0, alarm_red(0), S_STOP);
        for (int i = 1; i < 10; i++) begin
            tick();
            check_outs("tg_stop_hold", 0, 0, alarm_red(i), S_STOP);
        end
        card_valid = 1'b1;
        tick();
        check_outs("tg_reopen", 1, 1, 0, S_OPEN);
        card_valid = 1'b0;
        sensor_entrance = 1'b0;
        tick();
        check_outs("tg_pass", 0, 0, 0, S_IDLE);
        sensor_exit = 1'b0;
        card_valid = 1'b1;
        tick();
        tick();
        check_outs("tg_card_idle", 0, 0, 0, S_IDLE);
        card_valid = 1'b0;

        // STOP exits to IDLE only once both sensors are clear.
        sensor_entrance = 1'b1;
        tick();
        card_valid = 1'b1;
        tick();
        card_valid = 1'b0;
        sensor_exit = 1'b1;
        tick();
        sensor_exit = 1'b0;
        tick();
        check_outs("stop_entr_only", 0, 0, alarm_red(1), S_STOP);
        sensor_entrance = 1'b0;
        tick();
        check_outs("stop_clear", 0, 0, 0, S_IDLE);

        // Card timeout: 64 cycles in WAIT_CARD, 32 in DENIED, back to WAIT_CARD.
        sensor_entrance = 1'b1;
        tick();
        check_outs("to_wait0", 0, 0, 1, S_WAIT);
        for (int i = 1; i < 64; i++) begin
            tick();
            check_outs("to_wait", 0, 0, 1, S_WAIT);
        end
        tick();
        check_outs("to_denied0", 0, 0, alarm_red(0), S_DENIED);
        for (int i = 1; i < 32; i++) begin
            tick();
            check_outs("to_denied", 0, 0, alarm_red(i), S_DENIED);
        end
        tick();
        check_outs("to_rewait", 0, 0, 1, S_WAIT);

        // Second timeout: card ignored in DENIED, entrance cleared so DENIED ends in IDLE.
        repeat (63) tick();
        check_outs("to2_last_wait", 0, 0, 1, S_WAIT);
        tick();
        check_outs("to2_denied0", 0, 0, alarm_red(0), S_DENIED);
        card_valid = 1'b1;
        tick();
        check_outs("to2_card_ign", 0, 0, alarm_red(1), S_DENIED);
        card_valid = 1'b0;
        sensor_entrance = 1'b0;
        for (int i = 2; i < 32; i++) tick();
        check_outs("to2_denied_end", 0, 0, alarm_red(31), S_DENIED);
        tick();
        check_outs("to2_idle", 0, 0, 0, S_IDLE);

        // Abort: entrance drops on the same edge as the card.
        sensor_entrance = 1'b1;
        tick();
        sensor_entrance = 1'b0;
        card_valid = 1'b1;
        tick();
        check_outs("abort_idle", 0, 0, 0, S_IDLE);
        card_valid = 1'b0;

        // Asynchronous reset while OPEN closes the door before any clock edge.
        sensor_entrance = 1'b1;
        tick();
        card_valid = 1'b1;
        tick();
        check_outs("arst_open", 1, 1, 0, S_OPEN);
        card_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_outs("arst_now", 0, 0, 0, S_IDLE);
        sensor_entrance = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_outs("arst_after", 0, 0, 0, S_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
